// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter sharing the D$ slave port between the LSU (m0) and the
// cache-op/uncached unit (m1). Grant is locked to the owner while the slave stalls.
`ifndef DBUS_TRANS_WIDTH
`define DBUS_TRANS_WIDTH 8
`endif

module dbus_arbiter #(
    parameter int unsigned TRANS_W    = `DBUS_TRANS_WIDTH,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic               clk,
    input  logic               resetn,

    input  logic               m0_read,
    input  logic               m0_write,
    input  logic               m0_invalidate,
    input  logic               m0_invalidate_icache,
    input  logic [31:0]        m0_address,
    input  logic [31:0]        m0_wrdata,
    input  logic [3:0]         m0_byteenable,
    input  logic [TRANS_W-1:0] m0_trans_in,
    output logic               m0_stall,
    output logic [31:0]        m0_rddata,
    output logic [TRANS_W-1:0] m0_trans_out,

    input  logic               m1_read,
    input  logic               m1_write,
    input  logic               m1_invalidate,
    input  logic               m1_invalidate_icache,
    input  logic [31:0]        m1_address,
    input  logic [31:0]        m1_wrdata,
    input  logic [3:0]         m1_byteenable,
    input  logic [TRANS_W-1:0] m1_trans_in,
    output logic               m1_stall,
    output logic [31:0]        m1_rddata,
    output logic [TRANS_W-1:0] m1_trans_out,

    output logic               s_read,
    output logic               s_write,
    output logic               s_invalidate,
    output logic               s_invalidate_icache,
    output logic [31:0]        s_address,
    output logic [31:0]        s_wrdata,
    output logic [3:0]         s_byteenable,
    output logic [TRANS_W-1:0] s_trans_in,
    input  logic               s_stall,
    input  logic [31:0]        s_rddata,
    input  logic [TRANS_W-1:0] s_trans_out
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e state_q, state_d;
    logic   lock_owner_q, lock_owner_d;
    logic   rr_last_q, rr_last_d;

    logic req0, req1;
    logic grant_valid, grant, granted_req, sel1;

    assign req0 = m0_read | m0_write | m0_invalidate | m0_invalidate_icache;
    assign req1 = m1_read | m1_write | m1_invalidate | m1_invalidate_icache;

    // Grant depends only on requests and registered state, never on s_stall.
    always_comb begin
        grant_valid = 1'b0;
        grant       = 1'b0;
        if (state_q == StLocked) begin
            grant_valid = 1'b1;
            grant       = lock_owner_q;
        end else if (req0 && req1) begin
            grant_valid = 1'b1;
            grant       = FIXED_PRIO ? 1'b0 : ~rr_last_q;
        end else if (req0) begin
            grant_valid = 1'b1;
            grant       = 1'b0;
        end else if (req1) begin
            grant_valid = 1'b1;
            grant       = 1'b1;
        end
    end

    assign granted_req = grant ? req1 : req0;
    assign sel1        = grant_valid & grant;

    always_comb begin
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        rr_last_d    = rr_last_q;
        case (state_q)
            StIdle: begin
                if (grant_valid && granted_req && s_stall) begin
                    state_d      = StLocked;
                    lock_owner_d = grant;
                end
            end
            StLocked: begin
                if (!s_stall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (grant_valid && granted_req && !s_stall) begin
            rr_last_d = grant;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            lock_owner_q <= 1'b0;
            rr_last_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            rr_last_q    <= rr_last_d;
        end
    end

    always_comb begin
        s_read              = 1'b0;
        s_write             = 1'b0;
        s_invalidate        = 1'b0;
        s_invalidate_icache = 1'b0;
        if (resetn && grant_valid) begin
            s_read              = sel1 ? m1_read              : m0_read;
            s_write             = sel1 ? m1_write             : m0_write;
            s_invalidate        = sel1 ? m1_invalidate        : m0_invalidate;
            s_invalidate_icache = sel1 ? m1_invalidate_icache : m0_invalidate_icache;
        end
    end

    assign s_address    = sel1 ? m1_address    : m0_address;
    assign s_wrdata     = sel1 ? m1_wrdata     : m0_wrdata;
    assign s_byteenable = sel1 ? m1_byteenable : m0_byteenable;
    assign s_trans_in   = sel1 ? m1_trans_in   : m0_trans_in;

    // Granted master sees the slave stall; a losing requester is held off.
    always_comb begin
        m0_stall = 1'b1;
        m1_stall = 1'b1;
        if (resetn) begin
            m0_stall = (grant_valid && !grant) ? s_stall : req0;
            m1_stall = (grant_valid &&  grant) ? s_stall : req1;
        end
    end

    assign m0_rddata    = s_rddata;
    assign m1_rddata    = s_rddata;
    assign m0_trans_out = s_trans_out;
    assign m1_trans_out = s_trans_out;

`ifndef SYNTHESIS
    lock_req_held: assert property (@(posedge clk) disable iff (!resetn)
        (state_q == StLocked) |-> granted_req)
        else $error("dbus_arbiter: lock owner dropped its request while locked");
`endif

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: constant vector table, directed corner sequences and a random
// run against a transaction-level reference model, on a round-robin and a fixed-priority DUT.
module tb_dbus_arbiter;

    localparam int TW = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic rd[2], wr[2], inv[2], invi[2];
    logic [31:0] addr[2], wd[2];
    logic [3:0] be[2];
    logic [TW-1:0] tin[2];
    logic s_stall;
    logic [31:0] s_rddata;
    logic [TW-1:0] s_trans_out;

    // Outputs indexed by instance: 0 = round-robin, 1 = fixed priority.
    logic o_rd[2], o_wr[2], o_inv[2], o_invi[2];
    logic [31:0] o_addr[2], o_wd[2];
    logic [3:0] o_be[2];
    logic [TW-1:0] o_tin[2];
    logic o_stall0[2], o_stall1[2];
    logic [31:0] o_rdata0[2], o_rdata1[2];
    logic [TW-1:0] o_tout0[2], o_tout1[2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        dbus_arbiter #(
            .TRANS_W   (TW),
            .FIXED_PRIO(k == 1)
        ) u_dut (
            .clk                 (clk),
            .resetn              (resetn),
            .m0_read             (rd[0]),
            .m0_write            (wr[0]),
            .m0_invalidate       (inv[0]),
            .m0_invalidate_icache(invi[0]),
            .m0_address          (addr[0]),
            .m0_wrdata           (wd[0]),
            .m0_byteenable       (be[0]),
            .m0_trans_in         (tin[0]),
            .m0_stall            (o_stall0[k]),
            .m0_rddata           (o_rdata0[k]),
            .m0_trans_out        (o_tout0[k]),
            .m1_read             (rd[1]),
            .m1_write            (wr[1]),
            .m1_invalidate       (inv[1]),
            .m1_invalidate_icache(invi[1]),
            .m1_address          (addr[1]),
            .m1_wrdata           (wd[1]),
            .m1_byteenable       (be[1]),
            .m1_trans_in         (tin[1]),
            .m1_stall            (o_stall1[k]),
            .m1_rddata           (o_rdata1[k]),
            .m1_trans_out        (o_tout1[k]),
            .s_read              (o_rd[k]),
            .s_write             (o_wr[k]),
            .s_invalidate        (o_inv[k]),
            .s_invalidate_icache (o_invi[k]),
            .s_address           (o_addr[k]),
            .s_wrdata            (o_wd[k]),
            .s_byteenable        (o_be[k]),
            .s_trans_in          (o_tin[k]),
            .s_stall             (s_stall),
            .s_rddata            (s_rddata),
            .s_trans_out         (s_trans_out)
        );
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference model: owner of the outstanding transaction (-1 = none) and last master served.
    int m_lock[2];
    int m_last[2];
    bit exp_st[2];

    function automatic bit req(input int i);
        return rd[i] | wr[i] | inv[i] | invi[i];
    endfunction

    function automatic void model_grant(input int k, output bit gv, output int g);
        gv = 1'b1;
        g  = 0;
        if (m_lock[k] >= 0)          g = m_lock[k];
        else if (req(0) && req(1))   g = (k == 1) ? 0 : 1 - m_last[k];
        else if (req(0))             g = 0;
        else if (req(1))             g = 1;
        else                         gv = 1'b0;
    endfunction

    task automatic model_check_and_step();
        bit gv;
        int g;
        logic [5:0] act_ctl, exp_ctl;
        logic [31:0] rdata_g;
        logic [TW-1:0] tout_g;
        for (int k = 0; k < 2; k++) begin
            act_ctl = {o_rd[k], o_wr[k], o_inv[k], o_invi[k], o_stall0[k], o_stall1[k]};
            if (!resetn) begin
                check($sformatf("reset_ctl%0d", k), {26'd0, act_ctl}, 32'b000011);
                m_lock[k] = -1;
                m_last[k] = 1;
                if (k == 0) begin
                    exp_st[0] = 1'b1;
                    exp_st[1] = 1'b1;
                end
            end else begin
                model_grant(k, gv, g);
                exp_ctl[5:2] = gv ? {rd[g], wr[g], inv[g], invi[g]} : 4'b0;
                exp_ctl[1]   = (gv && g == 0) ? s_stall : req(0);
                exp_ctl[0]   = (gv && g == 1) ? s_stall : req(1);
                check($sformatf("model_ctl%0d", k), {26'd0, act_ctl}, {26'd0, exp_ctl});
                if (gv) begin
                    check($sformatf("model_addr%0d", k), o_addr[k], addr[g]);
                    check($sformatf("model_wdata%0d", k), o_wd[k], wd[g]);
                    check($sformatf("model_be%0d", k), {28'd0, o_be[k]}, {28'd0, be[g]});
                    check($sformatf("model_tin%0d", k), {24'd0, o_tin[k]}, {24'd0, tin[g]});
                    if (req(g) && !s_stall) begin
                        rdata_g = (g == 1) ? o_rdata1[k] : o_rdata0[k];
                        tout_g  = (g == 1) ? o_tout1[k] : o_tout0[k];
                        check($sformatf("model_rdata%0d", k), rdata_g, s_rddata);
                        check($sformatf("model_tout%0d", k), {24'd0, tout_g}, {24'd0, s_trans_out});
                    end
                end
                if (k == 0) begin
                    exp_st[0] = exp_ctl[1];
                    exp_st[1] = exp_ctl[0];
                end
                if (gv && req(g) && !s_stall) begin
                    m_last[k] = g;
                    m_lock[k] = -1;
                end else if (m_lock[k] >= 0 && !s_stall) begin
                    m_lock[k] = -1;
                end else if (gv && req(g) && s_stall) begin
                    m_lock[k] = g;
                end
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check_and_step();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 idle, 1 read, 2 write, 3 invalidate, 4 invalidate_icache
    task automatic set_req(input int i, input int kind, input logic [31:0] a);
        rd[i]   = (kind == 1);
        wr[i]   = (kind == 2);
        inv[i]  = (kind == 3);
        invi[i] = (kind == 4);
        addr[i] = a;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        sample();
        advance();
        resetn = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  reqs;   // {rd0, wr0, rd1, wr1}
        logic        stall;
        logic [5:0]  ctl;    // {read, write, inv, invi, m0_stall, m1_stall}
        logic [31:0] addr;
        logic [5:0]  fctl;
    } vec_t;

    vec_t vecs[10];

    initial begin
        for (int i = 0; i < 2; i++) begin
            set_req(i, 0, 32'h0);
            wd[i]  = 32'h1111_0000 * (i + 1);
            be[i]  = 4'hF;
            tin[i] = TW'(i + 1);
        end
        s_stall     = 1'b0;
        s_rddata    = 32'h0;
        s_trans_out = '0;
        apply_reset();

        // Single master with a three-cycle slave stall.
        set_req(0, 1, 32'h100);
        for (int c = 0; c < 4; c++) begin
            s_stall  = (c < 3);
            s_rddata = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
            sample();
            check("single_sread", {31'd0, o_rd[0]}, 32'd1);
            check("single_addr", o_addr[0], 32'h100);
            check("single_m0stall", {31'd0, o_stall0[0]}, {31'd0, c < 3});
            check("single_m1stall", {31'd0, o_stall1[0]}, 32'd0);
            if (c == 3) check("single_rdata", o_rdata0[0], 32'hDEAD_BEEF);
            advance();
        end
        set_req(0, 0, 32'h0);
        s_stall = 1'b0;

        // Contention from reset and sustained alternation.
        apply_reset();
        vecs[0] = '{4'b0110, 1'b0, 6'b010001, 32'h200, 6'b010001};
        vecs[1] = '{4'b0110, 1'b0, 6'b100010, 32'h300, 6'b010001};
        for (int v = 2; v < 10; v++) begin
            vecs[v] = (v % 2 == 0) ? '{4'b1010, 1'b0, 6'b100001, 32'h200, 6'b100001}
                                   : '{4'b1010, 1'b0, 6'b100010, 32'h300, 6'b100001};
        end
        for (int v = 0; v < 10; v++) begin
            rd[0] = vecs[v].reqs[3];
            wr[0] = vecs[v].reqs[2];
            rd[1] = vecs[v].reqs[1];
            wr[1] = vecs[v].reqs[0];
            addr[0] = 32'h200;
            addr[1] = 32'h300;
            s_stall = vecs[v].stall;
            sample();
            check($sformatf("vec%0d_ctl", v),
                  {26'd0, o_rd[0], o_wr[0], o_inv[0], o_invi[0], o_stall0[0], o_stall1[0]},
                  {26'd0, vecs[v].ctl});
            check($sformatf("vec%0d_addr", v), o_addr[0], vecs[v].addr);
            check($sformatf("vec%0d_fixed_ctl", v),
                  {26'd0, o_rd[1], o_wr[1], o_inv[1], o_invi[1], o_stall0[1], o_stall1[1]},
                  {26'd0, vecs[v].fctl});
            check($sformatf("vec%0d_fixed_addr", v), o_addr[1], 32'h200);
            advance();
        end
        set_req(0, 0, 32'h0);
        set_req(1, 0, 32'h0);
        sample();
        advance();

        // Lock hold: m1 stalled five cycles, m0 arrives during the stall.
        set_req(1, 1, 32'h300);
        for (int c = 0; c < 6; c++) begin
            s_stall = (c < 5);
            if (c == 1) set_req(0, 1, 32'h200);
            sample();
            check("lock_addr", o_addr[0], 32'h300);
            check("lock_m1stall", {31'd0, o_stall1[0]}, {31'd0, c < 5});
            check("lock_m0stall", {31'd0, o_stall0[0]}, {31'd0, c >= 1});
            advance();
        end
        set_req(1, 0, 32'h0);
        sample();
        check("lock_next_addr", o_addr[0], 32'h200);
        check("lock_next_m0stall", {31'd0, o_stall0[0]}, 32'd0);
        advance();
        set_req(0, 0, 32'h0);

        // Reset while locked to m1.
        set_req(1, 1, 32'h300);
        s_stall = 1'b1;
        sample();
        advance();
        resetn = 1'b0;
        sample();
        check("rst_strobes", {28'd0, o_rd[0], o_wr[0], o_inv[0], o_invi[0]}, 32'd0);
        check("rst_stalls", {30'd0, o_stall0[0], o_stall1[0]}, 32'd3);
        advance();
        set_req(0, 1, 32'h200);
        sample();
        advance();
        resetn  = 1'b1;
        s_stall = 1'b0;
        sample();
        check("rst_after_addr", o_addr[0], 32'h200);
        check("rst_after_m1stall", {31'd0, o_stall1[0]}, 32'd1);
        advance();
        set_req(0, 0, 32'h0);
        set_req(1, 0, 32'h0);

        // Invalidate-icache with side-band pass-through.
        set_req(1, 4, 32'h440);
        tin[1]      = TW'(5);
        s_trans_out = TW'(8'hA3);
        sample();
        check("inv_strobe", {31'd0, o_invi[0]}, 32'd1);
        check("inv_trans_in", {24'd0, o_tin[0]}, 32'h5);
        check("inv_trans_out", {24'd0, o_tout1[0]}, 32'hA3);
        advance();
        set_req(1, 0, 32'h0);

        // Random traffic; a stalled master holds its request fields.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!exp_st[i]) begin
                    int kind;
                    kind = $urandom_range(0, 5);
                    if (kind > 4) kind = 1;
                    set_req(i, kind, $urandom() & 32'hFFFF_FFFC);
                    wd[i]  = $urandom();
                    be[i]  = 4'($urandom());
                    tin[i] = TW'($urandom());
                end
            end
            s_stall     = ($urandom_range(0, 9) < 4);
            s_rddata    = $urandom();
            s_trans_out = TW'($urandom());
            sample();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
